pht_counter_table: RTL and testbench
====================================

Name: pht_counter_table

Overview:
- Parametrised pattern-history table: 2^IDX_W independent CTR_W-bit saturating counters, trained by resolved branches and read by the fetch-stage predictor.
- Generalises the single 2-bit training counter to a width- and depth-configurable indexed table.
- Adds a registered predict port, a train port, and same-cycle read/write bypass.
- Sits between fetch (predict) and branch resolution (train) in the front end.

Parameters:
- CTR_W, 2: counter width in bits (>=1).
- IDX_W, 7: index width; table depth = 2^IDX_W entries.
- INIT, 2^(CTR_W-1)-1: reset value of every counter (weakly not-taken); must be < 2^CTR_W.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- areset  input  1  asynchronous active-high reset.
- predict_valid  input  1  lookup request this cycle.
- predict_idx  input  IDX_W  lookup index (low PC bits).
- predict_out_valid  output  1  registered: lookup result valid.
- predict_taken  output  1  registered: MSB of looked-up counter.
- predict_state  output  CTR_W  registered: full looked-up counter value.
- train_valid  input  1  training request this cycle.
- train_idx  input  IDX_W  index to train.
- train_taken  input  1  resolved outcome; ignored (may be X) when train_valid=0.

Behaviour:
- Reset (async, immediate on areset=1):
  - all 2^IDX_W counters = INIT;
  - predict_out_valid=0, predict_taken=0, predict_state=0.
  - areset held: no training, no lookup. First edge after release behaves normally.
- Train, on a clk edge with train_valid=1:
  - ctr[train_idx] <= train_taken ? min(ctr+1, 2^CTR_W-1) : max(ctr-1, 0).
  - Saturates and never wraps: taken at max stays max, not-taken at 0 stays 0.
- train_valid=0: no counter changes. train_taken is don't-care and must not affect state even if X.
- Predict (1-cycle latency): on an edge with predict_valid=1:
  - predict_state <= ctr[predict_idx] value after this cycle's train update (write-first bypass);
  - predict_taken <= MSB of that value;
  - predict_out_valid <= 1.
- predict_valid=0: predict_out_valid <= 0; predict_state/predict_taken hold their previous values.
- Collision (train_idx == predict_idx, both valid): the prediction reflects the trained (saturated) value.
- Different indices in the same cycle: independent, no interference.
- No backpressure: one predict and one train accepted every cycle.
- Mid-operation reset clears outputs and counters; any in-flight lookup is discarded.

Optional Feature:
- Macro PHT_GSHARE_EN.
- When defined:
  - IDX_W-bit global history register ghr, reset 0 asynchronously.
  - Effective index = idx ^ ghr on both ports.
  - On train_valid, ghr <= {ghr[IDX_W-2:0], train_taken}, applied after this cycle's index computation; IDX_W=1 → ghr <= train_taken.
  - Adds output predict_ghr (IDX_W, registered with the lookup): the ghr used for that lookup.
- When undefined: no ghr, no predict_ghr port, index used directly.

Test Plan:
- Reset, CTR_W=2: assert areset mid-cycle → predict_out_valid=0 before the next edge. Then predict idx 5 → state=1, taken=0.
- Count up/down idx 3: train taken ×4 → predicts 2,3,3,3 (saturates at 3). Train not-taken ×4 → 2,1,0,0 (saturates at 0).
- Bypass: ctr[9]=1; same cycle train idx 9 taken + predict idx 9 → next cycle state=2, taken=1. Different indices → predict returns old value.
- train_valid=0 with train_taken=X for 10 cycles → all counters unchanged. predict_valid=0 → out_valid=0, state held.
- CTR_W=3, IDX_W=4: INIT=3; 5 taken trains idx 15 → 7 (saturated), taken=1; idx 0 untouched = 3.
- PHT_GSHARE_EN, IDX_W=4: train idx 2 taken (ghr 0→1); predict idx 3 → reads ctr[2]=2, predict_ghr=1.

Source files
------------

// File: rtl/pht_counter_table.sv
// pht_counter_table: indexed table of saturating branch counters with registered predict port, train port, write-first bypass; optional gshare indexing under PHT_GSHARE_EN
module pht_counter_table #(
  parameter int CTR_W = 2,
  parameter int IDX_W = 7,
  parameter int INIT  = 2**(CTR_W-1)-1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             predict_valid,
  input  logic [IDX_W-1:0] predict_idx,
  output logic             predict_out_valid,
  output logic             predict_taken,
  output logic [CTR_W-1:0] predict_state,
`ifdef PHT_GSHARE_EN
  output logic [IDX_W-1:0] predict_ghr,
`endif
  input  logic             train_valid,
  input  logic [IDX_W-1:0] train_idx,
  input  logic             train_taken
);
  localparam int DEPTH = 2**IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(INIT);
  logic [CTR_W-1:0] r_ctr [DEPTH];
  logic [IDX_W-1:0] w_tidx, w_pidx;
  logic [CTR_W-1:0] w_cur, w_inc, w_dec, w_next, w_look;
  logic             w_hit;
`ifdef PHT_GSHARE_EN
  logic [IDX_W-1:0] r_ghr, w_ghr_next;
  assign w_tidx = train_idx ^ r_ghr;
  assign w_pidx = predict_idx ^ r_ghr;
  if (IDX_W == 1) begin : g_ghr1
    assign w_ghr_next = train_taken;
  end else begin : g_ghrn
    assign w_ghr_next = {r_ghr[IDX_W-2:0], train_taken};
  end
  // history shifts in each resolved outcome; the lookup captures the history it was indexed with
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      r_ghr       <= '0;
      predict_ghr <= '0;
    end else begin
      if (train_valid) r_ghr <= w_ghr_next;
      if (predict_valid) predict_ghr <= r_ghr;
    end
`else
  assign w_tidx = train_idx;
  assign w_pidx = predict_idx;
`endif
  // saturating step of the entry being trained; train_taken only matters when train_valid
  always_comb begin
    w_cur  = r_ctr[w_tidx];
    w_inc  = (w_cur == CTR_MAX) ? CTR_MAX : w_cur + CTR_W'(1);
    w_dec  = (w_cur == '0) ? '0 : w_cur - CTR_W'(1);
    w_next = train_taken ? w_inc : w_dec;
    w_hit  = train_valid && (w_tidx == w_pidx);
    w_look = w_hit ? w_next : r_ctr[w_pidx];
  end
  // counter table: reset to INIT, one entry trained per cycle
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) r_ctr[i] <= CTR_RST;
    end else if (train_valid) begin
      r_ctr[w_tidx] <= w_next;
    end
  // registered lookup result; value held while no lookup is issued
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      predict_out_valid <= 1'b0;
      predict_taken     <= 1'b0;
      predict_state     <= '0;
    end else begin
      predict_out_valid <= predict_valid;
      if (predict_valid) begin
        predict_state <= w_look;
        predict_taken <= w_look[CTR_W-1];
      end
    end
endmodule

// File: tb/tb_pht_counter_table.sv
// tb_pht_counter_table: directed self-checking bench for pht_counter_table
module tb_pht_counter_table;
  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic       a_pv = 0, a_tv = 0, a_tt = 0;
  logic [6:0] a_pi = 0, a_ti = 0;
  logic       a_ov, a_tk;
  logic [1:0] a_st;
  logic       b_pv = 0, b_tv = 0, b_tt = 0;
  logic [3:0] b_pi = 0, b_ti = 0;
  logic       b_ov, b_tk;
  logic [2:0] b_st;
  logic       c_pv = 0, c_tv = 0, c_tt = 0;
  logic [3:0] c_pi = 0, c_ti = 0;
  logic       c_ov, c_tk;
  logic [1:0] c_st;
`ifdef PHT_GSHARE_EN
  logic [6:0] a_gh;
  logic [3:0] b_gh, c_gh;
`endif
  pht_counter_table dut_a (
    .clk(clk), .areset(areset), .predict_valid(a_pv), .predict_idx(a_pi),
    .predict_out_valid(a_ov), .predict_taken(a_tk), .predict_state(a_st),
`ifdef PHT_GSHARE_EN
    .predict_ghr(a_gh),
`endif
    .train_valid(a_tv), .train_idx(a_ti), .train_taken(a_tt));
  pht_counter_table #(.CTR_W(3), .IDX_W(4)) dut_b (
    .clk(clk), .areset(areset), .predict_valid(b_pv), .predict_idx(b_pi),
    .predict_out_valid(b_ov), .predict_taken(b_tk), .predict_state(b_st),
`ifdef PHT_GSHARE_EN
    .predict_ghr(b_gh),
`endif
    .train_valid(b_tv), .train_idx(b_ti), .train_taken(b_tt));
  pht_counter_table #(.CTR_W(2), .IDX_W(4)) dut_c (
    .clk(clk), .areset(areset), .predict_valid(c_pv), .predict_idx(c_pi),
    .predict_out_valid(c_ov), .predict_taken(c_tk), .predict_state(c_st),
`ifdef PHT_GSHARE_EN
    .predict_ghr(c_gh),
`endif
    .train_valid(c_tv), .train_idx(c_ti), .train_taken(c_tt));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total_cnt++; if (a_ov !== 1'b0) $display("FAIL rst_ov got %b want 0", a_ov); else pass_cnt++;
    total_cnt++; if (a_st !== 2'd0) $display("FAIL rst_state got %0d want 0", a_st); else pass_cnt++;
    total_cnt++; if (a_tk !== 1'b0) $display("FAIL rst_taken got %b want 0", a_tk); else pass_cnt++;
    step();
    step();
    areset = 1'b0;
    a_pv = 1; a_pi = 7'd5;
    step();
    a_pv = 0;
    total_cnt++; if (a_ov !== 1'b1) $display("FAIL idx5_ov got %b want 1", a_ov); else pass_cnt++;
    total_cnt++; if (a_st !== 2'd1) $display("FAIL idx5_state got %0d want 1", a_st); else pass_cnt++;
    total_cnt++; if (a_tk !== 1'b0) $display("FAIL idx5_taken got %b want 0", a_tk); else pass_cnt++;
    a_tv = 1; a_ti = 7'd5; a_tt = 1;
    step();
    a_tv = 0;
    #2 areset = 1'b1;
    #1;
    total_cnt++; if (a_ov !== 1'b0) $display("FAIL midrst_ov got %b want 0", a_ov); else pass_cnt++;
    total_cnt++; if (a_st !== 2'd0) $display("FAIL midrst_state got %0d want 0", a_st); else pass_cnt++;
    #1 areset = 1'b0;
    a_pv = 1; a_pi = 7'd5;
    step();
    a_pv = 0;
    total_cnt++; if (a_st !== 2'd1) $display("FAIL midrst_ctr got %0d want 1", a_st); else pass_cnt++;
  endtask

  task automatic test_count();
    logic [1:0] up [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
    logic [1:0] dn [4] = '{2'd2, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 8; i++) begin
      logic [1:0] e;
      e = (i < 4) ? up[i] : dn[i-4];
      a_tv = 1; a_ti = 7'd3; a_tt = (i < 4);
      a_pv = 1; a_pi = 7'd3;
      step();
      total_cnt++; if (a_st !== e) $display("FAIL count%0d_state got %0d want %0d", i, a_st, e); else pass_cnt++;
      total_cnt++; if (a_tk !== e[1]) $display("FAIL count%0d_taken got %b want %b", i, a_tk, e[1]); else pass_cnt++;
    end
    a_tv = 0; a_pv = 0;
  endtask

  task automatic test_bypass();
    a_tv = 1; a_ti = 7'd9; a_tt = 1;
    a_pv = 1; a_pi = 7'd9;
    step();
    total_cnt++; if (a_st !== 2'd2) $display("FAIL byp_state got %0d want 2", a_st); else pass_cnt++;
    total_cnt++; if (a_tk !== 1'b1) $display("FAIL byp_taken got %b want 1", a_tk); else pass_cnt++;
    a_ti = 7'd10; a_pi = 7'd11;
    step();
    total_cnt++; if (a_st !== 2'd1) $display("FAIL diff_state got %0d want 1", a_st); else pass_cnt++;
    a_tv = 0; a_pi = 7'd10;
    step();
    total_cnt++; if (a_st !== 2'd2) $display("FAIL diff_trained got %0d want 2", a_st); else pass_cnt++;
    a_pv = 0;
  endtask

  task automatic test_idle();
    a_pv = 0; a_tv = 0; a_tt = 1'bx; a_ti = 7'd9;
    for (int i = 0; i < 10; i++) step();
    total_cnt++; if (a_ov !== 1'b0) $display("FAIL idle_ov got %b want 0", a_ov); else pass_cnt++;
    total_cnt++; if (a_st !== 2'd2) $display("FAIL idle_hold got %0d want 2", a_st); else pass_cnt++;
    a_tt = 0;
    a_pv = 1; a_pi = 7'd9;
    step();
    total_cnt++; if (a_st !== 2'd2) $display("FAIL idle_ctr9 got %0d want 2", a_st); else pass_cnt++;
    a_pi = 7'd3;
    step();
    total_cnt++; if (a_st !== 2'd0) $display("FAIL idle_ctr3 got %0d want 0", a_st); else pass_cnt++;
    a_pi = 7'd100;
    step();
    total_cnt++; if (a_st !== 2'd1) $display("FAIL idle_ctr100 got %0d want 1", a_st); else pass_cnt++;
    a_pv = 0;
  endtask

  task automatic test_wide();
    logic [2:0] exp [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
    b_pv = 1; b_pi = 4'd0;
    step();
    total_cnt++; if (b_st !== 3'd3) $display("FAIL wide_init got %0d want 3", b_st); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      b_tv = 1; b_ti = 4'd15; b_tt = 1; b_pi = 4'd15;
      step();
      total_cnt++; if (b_st !== exp[i]) $display("FAIL wide%0d_state got %0d want %0d", i, b_st, exp[i]); else pass_cnt++;
    end
    total_cnt++; if (b_tk !== 1'b1) $display("FAIL wide_taken got %b want 1", b_tk); else pass_cnt++;
    b_tv = 0; b_pi = 4'd0;
    step();
    total_cnt++; if (b_st !== 3'd3) $display("FAIL wide_idx0 got %0d want 3", b_st); else pass_cnt++;
    b_pv = 0;
  endtask

`ifdef PHT_GSHARE_EN
  task automatic test_gshare();
    c_tv = 1; c_ti = 4'd2; c_tt = 1;
    step();
    c_tv = 0;
    c_pv = 1; c_pi = 4'd3;
    step();
    c_pv = 0;
    total_cnt++; if (c_st !== 2'd2) $display("FAIL gs_state got %0d want 2", c_st); else pass_cnt++;
    total_cnt++; if (c_tk !== 1'b1) $display("FAIL gs_taken got %b want 1", c_tk); else pass_cnt++;
    total_cnt++; if (c_gh !== 4'd1) $display("FAIL gs_ghr got %0d want 1", c_gh); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
`ifdef PHT_GSHARE_EN
    test_gshare();
`else
    test_count();
    test_bypass();
    test_idle();
    test_wide();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
